// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if: 8-bit AXI-Stream bundle.
// Master drives data/valid/last/user, slave drives ready.
interface eth_rx_frame_fifo_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame buffer.
// Commits good frames only; replays them with backpressure.
module eth_rx_frame_fifo #(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic                aclk,
  input  logic                reset,
  eth_rx_frame_fifo_if.slave  s_axis,
  eth_rx_frame_fifo_if.master m_axis,
  output logic [ADDR_W:0]     frame_cnt,
  output logic [CNT_W-1:0]    drop_bad_cnt,
  output logic [CNT_W-1:0]    drop_ovf_cnt
);
  localparam int PW = ADDR_W + 1;
  localparam int DEPTH_N = 1 << ADDR_W;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } wstate_t;

  wstate_t       state;
  logic [8:0]    mem [DEPTH_N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  logic [8:0]    ram_q;
  logic          ram_vld;

  logic pop;
  logic out_load;
  logic rd_issue;
  logic full;
  logic beat;
  logic bad_end;
  logic do_write;
  logic do_commit;
  logic do_bad;
  logic do_rewind;
  logic do_ovf;
  logic frame_done;

  // The MAC cannot be stalled; tuser is not produced downstream.
  assign s_axis.tready = 1'b1;
  assign m_axis.tuser  = 1'b0;

  assign pop        = m_axis.tvalid & m_axis.tready;
  assign out_load   = ram_vld & (~m_axis.tvalid | pop);
  assign frame_done = pop & m_axis.tlast;

  // Fetch ahead whenever committed data exists and a slot frees up.
  assign rd_issue = (rd_ptr != wr_commit) & (~ram_vld | out_load);

  // A read issued this cycle frees its slot for the writer.
  assign full = ((wr_ptr - rd_ptr) == DEPTH) & ~rd_issue;

  assign beat      = s_axis.tvalid & (state != DROP);
  assign bad_end   = s_axis.tlast & s_axis.tuser;
  assign do_write  = beat & ~full & ~bad_end;
  assign do_commit = do_write & s_axis.tlast;
  assign do_bad    = beat & ~full & bad_end;
  assign do_rewind = do_bad | (beat & full);
  assign do_ovf    = s_axis.tvalid & s_axis.tlast
                   & ((beat & full) | (state == DROP));

  // Frame RAM: {tlast, tdata}, read-first, 1-cycle read.
  always_ff @(posedge aclk) begin
    if (do_write) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end
    if (rd_issue) begin
      ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  // Write FSM: speculative write, commit on good tlast, rewind on drop.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      wr_commit    <= '0;
      frame_cnt    <= '0;
      drop_bad_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (do_rewind) wr_ptr <= wr_commit;
      if (do_commit) wr_commit <= wr_ptr + PW'(1);
      frame_cnt <= frame_cnt + PW'(do_commit) - PW'(frame_done);
      if (do_bad && drop_bad_cnt != '1) begin
        drop_bad_cnt <= drop_bad_cnt + CNT_W'(1);
      end
      if (do_ovf && drop_ovf_cnt != '1) begin
        drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(1);
      end
      unique case (state)
        IDLE, RECV: begin
          if (beat) begin
            if (full && !s_axis.tlast) state <= DROP;
            else if (s_axis.tlast) state <= IDLE;
            else state <= RECV;
          end
        end
        DROP: begin
          if (s_axis.tvalid && s_axis.tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read side: RAM data stage feeding a held output register.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tdata  <= '0;
    end else begin
      if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
      ram_vld <= rd_issue | (ram_vld & ~out_load);
      if (out_load) begin
        m_axis.tlast <= ram_q[8];
        m_axis.tdata <= ram_q[7:0];
      end
      m_axis.tvalid <= out_load | (m_axis.tvalid & ~pop);
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: table vectors plus scoreboard
// for the RX frame FIFO at a 64-byte depth.
module tb_eth_rx_frame_fifo;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int CAP = 1 << AW;

  typedef struct {
    int len;
    bit bad;
    bit pass;
    int bad_cnt;
    int ovf_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW:0]   frame_cnt;
  logic [CW-1:0] drop_bad_cnt;
  logic [CW-1:0] drop_ovf_cnt;

  eth_rx_frame_fifo_if s_if ();
  eth_rx_frame_fifo_if m_if ();

  eth_rx_frame_fifo #(
    .ADDR_W(AW),
    .CNT_W (CW)
  ) dut (
    .aclk        (clk),
    .reset       (reset),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .frame_cnt   (frame_cnt),
    .drop_bad_cnt(drop_bad_cnt),
    .drop_ovf_cnt(drop_ovf_cnt)
  );

  always #5 clk = ~clk;

  int         nvec = 0;
  int         nerr = 0;
  int         out_cnt = 0;
  int         fc_peak = 0;
  logic [8:0] q[$];
  logic [8:0] held;
  bit         held_v = 0;
  bit         rmode = 0;
  bit         rfix = 1;
  vec_t       tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: fixed level or coin flip each cycle.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rmode ? 1'($urandom_range(0, 1)) : rfix;
    end
  end

  // Output monitor: scoreboard pop and stall-hold check.
  always @(negedge clk) begin
    if (int'(frame_cnt) > fc_peak) fc_peak = int'(frame_cnt);
    if (reset) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata},
            {1'b1, held});
      end
      if (m_if.tvalid && m_if.tready) begin
        held_v = 0;
        out_cnt++;
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_out: got %0h expected none",
                   {m_if.tlast, m_if.tdata});
        end else begin
          chk("out_byte", {m_if.tlast, m_if.tdata}, q.pop_front());
        end
      end else if (m_if.tvalid) begin
        held_v = 1;
        held = {m_if.tlast, m_if.tdata};
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic send_frame(input int len, input bit bad,
                            input logic [7:0] start, input bit push);
    for (int i = 0; i < len; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'(start + 8'(i));
      s_if.tlast  = (i == len - 1);
      s_if.tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      if (push) q.push_back({s_if.tlast, s_if.tdata});
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || m_if.tvalid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      nvec++;
      nerr++;
      $display("FAIL drain_%s: got %0d bytes left expected 0",
               tag, q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int o0;
    int n;
    int len;
    tbl[0] = '{15, 1'b1, 1'b0, 1, 0};
    tbl[1] = '{8,  1'b0, 1'b1, 1, 0};
    tbl[2] = '{100, 1'b0, 1'b0, 1, 1};
    tbl[3] = '{5,  1'b0, 1'b1, 1, 1};
    tbl[4] = '{64, 1'b0, 1'b1, 1, 1};
    tbl[5] = '{65, 1'b0, 1'b0, 1, 2};
    tbl[6] = '{64, 1'b1, 1'b0, 2, 2};
    tbl[7] = '{1,  1'b0, 1'b1, 2, 2};
    tbl[8] = '{1,  1'b1, 1'b0, 3, 2};

    reset = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    s_if.tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_bad", drop_bad_cnt, 0);
    chk("rst_ovf", drop_ovf_cnt, 0);
    chk("s_tready", s_if.tready, 1);
    chk("m_tuser", m_if.tuser, 0);

    // Two good frames, first-byte latency.
    fc_peak = 0;
    send_frame(10, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("lat_e1_tvalid", m_if.tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_e2_tvalid", m_if.tvalid, 1);
    send_frame(20, 1'b0, 8'h0a, 1'b1);
    wait_drain("two");
    chk("two_peak_ok", (fc_peak == 1 || fc_peak == 2), 1);
    chk("two_frame_cnt", frame_cnt, 0);
    chk("two_out_cnt", out_cnt, 30);

    // Table vectors with tready held high.
    for (int i = 0; i < 9; i++) begin
      o0 = out_cnt;
      send_frame(tbl[i].len, tbl[i].bad, 8'(i * 16), tbl[i].pass);
      wait_drain("tbl");
      chk($sformatf("tbl%0d_out", i), out_cnt - o0,
          tbl[i].pass ? tbl[i].len : 0);
      chk($sformatf("tbl%0d_bad", i), drop_bad_cnt, tbl[i].bad_cnt);
      chk($sformatf("tbl%0d_ovf", i), drop_ovf_cnt, tbl[i].ovf_cnt);
      chk($sformatf("tbl%0d_fc", i), frame_cnt, 0);
    end

    // Overflow with a stalled reader.
    rfix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    o0 = out_cnt;
    send_frame(40, 1'b0, 8'h40, 1'b1);
    send_frame(40, 1'b0, 8'h80, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf_frame_cnt", frame_cnt, 1);
    chk("ovf_cnt", drop_ovf_cnt, 3);
    chk("ovf_bad", drop_bad_cnt, 3);
    chk("ovf_stalled_out", out_cnt - o0, 0);
    rfix = 1'b1;
    wait_drain("ovf");
    chk("ovf_out_cnt", out_cnt - o0, 40);
    chk("ovf_fc_end", frame_cnt, 0);

    // Random ready over many good frames, pointers wrap.
    rmode = 1'b1;
    o0 = out_cnt;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 60);
      n = 0;
      while (q.size() + len > CAP && n < 3000) begin
        @(posedge clk);
        n++;
      end
      #1;
      send_frame(len, 1'b0, 8'($urandom), 1'b1);
    end
    wait_drain("rand");
    rmode = 1'b0;
    rfix = 1'b1;
    chk("rand_bad", drop_bad_cnt, 3);
    chk("rand_ovf", drop_ovf_cnt, 3);
    chk("rand_fc", frame_cnt, 0);
    chk("rand_q_empty", q.size(), 0);

    // Reset mid-frame with two frames stored.
    rfix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(10, 1'b0, 8'h11, 1'b1);
    send_frame(12, 1'b0, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata = 8'(8'h33 + 8'(i));
      s_if.tlast = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("pre_rst_fc", frame_cnt, 2);
    reset = 1'b1;
    s_if.tvalid = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", m_if.tvalid, 0);
    chk("mid_rst_tlast", m_if.tlast, 0);
    chk("mid_rst_tdata", m_if.tdata, 0);
    chk("mid_rst_fc", frame_cnt, 0);
    chk("mid_rst_bad", drop_bad_cnt, 0);
    chk("mid_rst_ovf", drop_ovf_cnt, 0);
    rfix = 1'b1;
    @(posedge clk);
    #1;
    o0 = out_cnt;
    send_frame(4, 1'b0, 8'h5a, 1'b1);
    wait_drain("post_rst");
    chk("post_rst_out", out_cnt - o0, 4);
    chk("post_rst_fc", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
